fabric_mem_responder: RTL and testbench

- Parametrised, synthesizable replacement for the fixed 3-cycle tile-33 memory model used by core benches.
- Accepts fabric WR/RD requests from a tile's fabric output and stores writes into a local byte memory.
- Returns each RD as an RD_RSP transaction after a programmable latency.
- Adds ready/valid backpressure on both sides, byte enables, an output response FIFO and transaction counters.

---
 rtl/fabric_mem_responder.sv | 173 +++++++++++++++++
 tb/tb_fabric_mem_responder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fabric_mem_responder.sv
// Fabric memory responder: byte memory with byte-enable writes and RD_RSP returns
// through a fixed-latency pipe and a credit-protected response FIFO.

package fabric_mem_responder_pkg;
    localparam logic [2:0] OP_WR     = 3'd1;
    localparam logic [2:0] OP_RD     = 3'd2;
    localparam logic [2:0] OP_RD_RSP = 3'd3;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [31:0] address;
        logic [31:0] data;
        logic [31:0] requestor_id;
        logic [3:0]  next_tile_fifo_arb_id;
    } t_tile_trans;
endpackage

module fabric_mem_responder
    import fabric_mem_responder_pkg::*;
#(
    parameter int unsigned MEM_BYTES   = 65536,
    parameter int unsigned OFFSET_MSB  = 23,
    parameter int unsigned RSP_LATENCY = 3,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic        Clock,
    input  logic        Rst,
    input  logic [7:0]  local_tile_id,
    input  logic        InReqValid,
    output logic        InReqReady,
    input  t_tile_trans InReq,
    input  logic [3:0]  InReqByteEn,
    output logic        OutRspValid,
    input  logic        OutRspReady,
    output t_tile_trans OutRsp,
    output logic [31:0] WrCount,
    output logic [31:0] RdCount,
    output logic        ErrBadOpcode
);
    localparam int unsigned ADDR_W = $clog2(MEM_BYTES);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + RSP_LATENCY) + 1;

    logic              reqAccept, wrAccept, rdAccept, badAccept;
    logic [ADDR_W-1:0] off;
    logic [31:0]       rdWord;
    t_tile_trans       capRsp;
    logic              pushValid;
    t_tile_trans       pushData;
    logic [CNT_W-1:0]  inflight;
    logic [PTR_W:0]    fifoCnt;
    logic [PTR_W-1:0]  wrPtr, rdPtr;
    logic              popFire;
    t_tile_trans       fifoMem [FIFO_DEPTH];
    logic [7:0]        mem [MEM_BYTES];
    logic              unusedReqBits;

    // Credits cover both the pipe and the FIFO, so every accepted RD has a slot.
    assign InReqReady = (CNT_W'(fifoCnt) + inflight) < CNT_W'(FIFO_DEPTH);
    assign reqAccept  = InReqValid && InReqReady;
    assign wrAccept   = reqAccept && (InReq.opcode == OP_WR);
    assign rdAccept   = reqAccept && (InReq.opcode == OP_RD);
    assign badAccept  = reqAccept && (InReq.opcode != OP_WR) && (InReq.opcode != OP_RD);
    assign off        = ADDR_W'(InReq.address[OFFSET_MSB:0]);
    assign unusedReqBits = ^InReq.requestor_id;

    // Little-endian word read; byte addresses wrap at the top of memory.
    always_comb begin
        rdWord = '0;
        for (int i = 0; i < 4; i++) begin
            rdWord[8*i +: 8] = mem[off + ADDR_W'(i)];
        end
    end

    always_comb begin
        capRsp                       = '0;
        capRsp.opcode                = OP_RD_RSP;
        capRsp.address               = {local_tile_id, InReq.address[23:0]};
        capRsp.data                  = rdWord;
        capRsp.requestor_id          = InReq.address;
        capRsp.next_tile_fifo_arb_id = InReq.next_tile_fifo_arb_id;
    end

    always_ff @(posedge Clock) begin
        if (wrAccept) begin
            for (int i = 0; i < 4; i++) begin
                if (InReqByteEn[i]) begin
                    mem[off + ADDR_W'(i)] <= InReq.data[8*i +: 8];
                end
            end
        end
    end

    // The accept cycle counts as the first latency cycle, so the pipe holds LATENCY-1 registers.
    generate
        if (RSP_LATENCY > 1) begin : gPipe
            localparam int unsigned STAGES = RSP_LATENCY - 1;
            logic [STAGES-1:0] stValid;
            t_tile_trans       stData [STAGES];

            always_ff @(posedge Clock or negedge Rst) begin
                if (!Rst) begin
                    stValid <= '0;
                end else begin
                    stValid[0] <= rdAccept;
                    for (int i = 1; i < STAGES; i++) begin
                        stValid[i] <= stValid[i-1];
                    end
                end
            end

            always_ff @(posedge Clock) begin
                stData[0] <= capRsp;
                for (int i = 1; i < STAGES; i++) begin
                    stData[i] <= stData[i-1];
                end
            end

            always_comb begin
                inflight = '0;
                for (int i = 0; i < STAGES; i++) begin
                    inflight = inflight + CNT_W'(stValid[i]);
                end
            end

            assign pushValid = stValid[STAGES-1];
            assign pushData  = stData[STAGES-1];
        end else begin : gNoPipe
            assign pushValid = rdAccept;
            assign pushData  = capRsp;
            assign inflight  = '0;
        end
    endgenerate

    assign OutRspValid = (fifoCnt != '0);
    assign OutRsp      = OutRspValid ? fifoMem[rdPtr] : '0;
    assign popFire     = OutRspValid && OutRspReady;

    always_ff @(posedge Clock) begin
        if (pushValid) begin
            fifoMem[wrPtr] <= pushData;
        end
    end

    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            wrPtr   <= '0;
            rdPtr   <= '0;
            fifoCnt <= '0;
        end else begin
            if (pushValid) wrPtr <= wrPtr + PTR_W'(1);
            if (popFire)   rdPtr <= rdPtr + PTR_W'(1);
            case ({pushValid, popFire})
                2'b10:   fifoCnt <= fifoCnt + (PTR_W+1)'(1);
                2'b01:   fifoCnt <= fifoCnt - (PTR_W+1)'(1);
                default: fifoCnt <= fifoCnt;
            endcase
        end
    end

    // Saturating transaction counters and sticky opcode error.
    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            WrCount      <= '0;
            RdCount      <= '0;
            ErrBadOpcode <= 1'b0;
        end else begin
            if (wrAccept && (WrCount != '1)) WrCount <= WrCount + 32'd1;
            if (rdAccept && (RdCount != '1)) RdCount <= RdCount + 32'd1;
            if (badAccept)                   ErrBadOpcode <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fabric_mem_responder.sv
// Randomized and directed bench for fabric_mem_responder against a queue-based
// reference model: accepted-but-unreturned RDs, each visible LAT cycles after accept.

module tb_fabric_mem_responder;
    import fabric_mem_responder_pkg::*;

    localparam int unsigned MEM_BYTES  = 65536;
    localparam int unsigned OFFSET_MSB = 23;
    localparam int unsigned LAT        = 3;
    localparam int unsigned DEPTH      = 4;
    localparam logic [7:0]  TILE       = 8'h22;

    logic Clock = 1'b0;
    always #5 Clock = ~Clock;

    logic        Rst;
    logic        reqValid, reqReady, rspValid, rspReady, errBad;
    t_tile_trans req, rsp;
    logic [3:0]  byteEn;
    logic [31:0] wrCount, rdCount;

    logic        l1Valid, l1Ready, l1RspValid, l1Err;
    t_tile_trans l1Req, l1Rsp;
    logic [31:0] l1WrCount, l1RdCount;

    fabric_mem_responder #(.MEM_BYTES(MEM_BYTES), .OFFSET_MSB(OFFSET_MSB),
                           .RSP_LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
        .Clock(Clock), .Rst(Rst), .local_tile_id(TILE),
        .InReqValid(reqValid), .InReqReady(reqReady), .InReq(req), .InReqByteEn(byteEn),
        .OutRspValid(rspValid), .OutRspReady(rspReady), .OutRsp(rsp),
        .WrCount(wrCount), .RdCount(rdCount), .ErrBadOpcode(errBad));

    fabric_mem_responder #(.MEM_BYTES(MEM_BYTES), .OFFSET_MSB(OFFSET_MSB),
                           .RSP_LATENCY(1), .FIFO_DEPTH(DEPTH)) dutL1 (
        .Clock(Clock), .Rst(Rst), .local_tile_id(TILE),
        .InReqValid(l1Valid), .InReqReady(l1Ready), .InReq(l1Req), .InReqByteEn(4'hF),
        .OutRspValid(l1RspValid), .OutRspReady(1'b1), .OutRsp(l1Rsp),
        .WrCount(l1WrCount), .RdCount(l1RdCount), .ErrBadOpcode(l1Err));

    typedef struct {
        t_tile_trans t;
        int          acc;
    } pend_t;

    int          checks = 0;
    int          errors = 0;
    int          cycle  = 0;
    int          accepts = 0;
    logic [7:0]  refMem [MEM_BYTES];
    pend_t       expQ[$];
    logic [31:0] wrCnt, rdCnt;
    logic        errExp;
    t_tile_trans lastRsp;

    task automatic checkVal(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One bus cycle: drive, compare against the model, then advance the model.
    task automatic step(input logic v, input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] be, input logic rdy);
        logic        expReady, expValid;
        int unsigned o;
        pend_t       e;
        @(negedge Clock);
        reqValid = v;
        req = '0;
        req.opcode = op;
        req.address = addr;
        req.data = data;
        req.next_tile_fifo_arb_id = addr[3:0] ^ data[7:4];
        byteEn = be;
        rspReady = rdy;
        #1;
        expReady = (expQ.size() < DEPTH);
        expValid = (expQ.size() > 0) && (cycle >= expQ[0].acc + int'(LAT));
        checkVal("inReqReady", reqReady, expReady);
        checkVal("outRspValid", rspValid, expValid);
        if (expValid) checkVal("outRsp", rsp, expQ[0].t);
        checkVal("wrCount", wrCount, wrCnt);
        checkVal("rdCount", rdCount, rdCnt);
        checkVal("errBadOpcode", errBad, errExp);
        if (v && reqReady) accepts++;
        if (expValid && rdy) begin
            lastRsp = rsp;
            void'(expQ.pop_front());
        end
        if (v && expReady) begin
            o = (addr & ((32'd1 << (OFFSET_MSB + 1)) - 32'd1)) % MEM_BYTES;
            if (op == OP_WR) begin
                for (int i = 0; i < 4; i++)
                    if (be[i]) refMem[(o + i) % MEM_BYTES] = data[8*i +: 8];
                if (wrCnt != 32'hFFFF_FFFF) wrCnt++;
            end else if (op == OP_RD) begin
                e.t = '0;
                e.t.opcode = OP_RD_RSP;
                e.t.address = {TILE, addr[23:0]};
                for (int i = 0; i < 4; i++) e.t.data[8*i +: 8] = refMem[(o + i) % MEM_BYTES];
                e.t.requestor_id = addr;
                e.t.next_tile_fifo_arb_id = req.next_tile_fifo_arb_id;
                e.acc = cycle;
                expQ.push_back(e);
                if (rdCnt != 32'hFFFF_FFFF) rdCnt++;
            end else begin
                errExp = 1'b1;
            end
        end
        cycle++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, OP_WR, 32'h0, 32'h0, 4'h0, 1'b1);
    endtask

    task automatic doReset();
        @(negedge Clock);
        reqValid = 1'b0;
        l1Valid = 1'b0;
        Rst = 1'b0;
        #1;
        checkVal("rstOutRspValid", rspValid, 1'b0);
        checkVal("rstOutRsp", rsp, '0);
        expQ.delete();
        wrCnt = '0;
        rdCnt = '0;
        errExp = 1'b0;
        repeat (2) @(negedge Clock);
        Rst = 1'b1;
    endtask

    initial begin
        logic [31:0] lastWr, d;
        int unsigned o;
        Rst = 1'b0;
        reqValid = 1'b0; req = '0; byteEn = 4'h0; rspReady = 1'b0;
        l1Valid = 1'b0; l1Req = '0;
        wrCnt = '0; rdCnt = '0; errExp = 1'b0; lastRsp = '0;
        repeat (2) @(negedge Clock);
        doReset();
        checkVal("rstInReqReady", reqReady, 1'b1);

        // Test 1: write then read, latency and response fields.
        step(1'b1, OP_WR, 32'h2200_0010, 32'hDEAD_BEEF, 4'hF, 1'b1);
        step(1'b1, OP_RD, 32'h2200_0010, 32'h0, 4'h0, 1'b1);
        idle(LAT + 1);
        checkVal("t1Data", lastRsp.data, 32'hDEAD_BEEF);
        checkVal("t1Addr", lastRsp.address, 32'h2200_0010);
        checkVal("t1ReqId", lastRsp.requestor_id, 32'h2200_0010);
        checkVal("t1Opcode", lastRsp.opcode, OP_RD_RSP);
        checkVal("t1WrCount", wrCount, 32'd1);
        checkVal("t1RdCount", rdCount, 32'd1);

        // Memory window 0xFFC0..0x003F (wrapping) made defined for later reads.
        for (int i = 0; i < 32; i++)
            step(1'b1, OP_WR, 32'h0000_FFC0 + 32'(i * 4), $urandom, 4'hF, 1'b1);

        // Test 2: byte enables merge.
        step(1'b1, OP_WR, 32'h2200_0020, 32'h1122_3344, 4'hF, 1'b1);
        step(1'b1, OP_WR, 32'h2200_0020, 32'hAABB_CCDD, 4'b0101, 1'b1);
        step(1'b1, OP_RD, 32'h2200_0020, 32'h0, 4'h0, 1'b1);
        idle(LAT + 1);
        checkVal("t2Data", lastRsp.data, 32'h11BB_33DD);

        // Test 3: wrap at the top of memory.
        step(1'b1, OP_WR, 32'h2200_FFFE, 32'hCAFE_F00D, 4'hF, 1'b1);
        step(1'b1, OP_RD, 32'h2200_FFFE, 32'h0, 4'h0, 1'b1);
        idle(LAT + 1);
        checkVal("t3Data", lastRsp.data, 32'hCAFE_F00D);
        step(1'b1, OP_RD, 32'h2200_0000, 32'h0, 4'h0, 1'b1);
        idle(LAT + 1);
        checkVal("t3Low", lastRsp.data[15:0], 16'hCAFE);
        step(1'b1, OP_RD, 32'h2200_FFFC, 32'h0, 4'h0, 1'b1);
        idle(LAT + 1);
        checkVal("t3High", lastRsp.data[31:16], 16'hF00D);

        // Test 4: backpressure fills credits, then drain in order.
        accepts = 0;
        for (int i = 0; i < 6; i++)
            step(1'b1, OP_RD, 32'h2200_0000 + 32'(i * 4), 32'h0, 4'h0, 1'b0);
        checkVal("t4Accepted", accepts, 4);
        for (int i = 0; i < 3; i++) step(1'b0, OP_WR, 32'h0, 32'h0, 4'h0, 1'b0);
        idle(6);

        // Test 5: bad opcode, then reset with responses queued and in flight.
        step(1'b1, OP_RD_RSP, 32'h2200_0020, 32'h5555_5555, 4'hF, 1'b1);
        idle(LAT + 1);
        checkVal("t5Err", errBad, 1'b1);
        step(1'b1, OP_RD, 32'h2200_0020, 32'h0, 4'h0, 1'b0);
        step(1'b1, OP_RD, 32'h2200_0024, 32'h0, 4'h0, 1'b0);
        for (int i = 0; i < 2; i++) step(1'b0, OP_WR, 32'h0, 32'h0, 4'h0, 1'b0);
        step(1'b1, OP_RD, 32'h2200_0028, 32'h0, 4'h0, 1'b0);
        doReset();
        idle(LAT + 3);
        checkVal("t5ErrCleared", errBad, 1'b0);
        step(1'b1, OP_RD, 32'h2200_0020, 32'h0, 4'h0, 1'b1);
        idle(LAT + 1);
        checkVal("t5MemKept", lastRsp.data, 32'h11BB_33DD);

        // Random traffic inside the defined window.
        for (int n = 0; n < 400; n++) begin
            int r;
            logic [2:0] op;
            r = int'($urandom_range(0, 19));
            op = (r < 9) ? OP_WR : (r < 19) ? OP_RD : 3'($urandom_range(3, 7));
            o = (32'hFFC0 + $urandom_range(0, 124)) % MEM_BYTES;
            step($urandom_range(0, 3) != 0, op,
                 {8'($urandom), 8'($urandom), 16'(o)}, $urandom,
                 4'($urandom), $urandom_range(0, 2) != 0);
        end
        idle(DEPTH + LAT + 2);

        // Latency-1 instance: alternating WR/RD returns the preceding write.
        lastWr = '0;
        for (int k = 0; k < 20; k++) begin
            @(negedge Clock);
            l1Valid = 1'b1;
            l1Req = '0;
            l1Req.address = 32'h2200_0100;
            #1;
            checkVal("l1Ready", l1Ready, 1'b1);
            if (k % 2 == 0) begin
                if (k > 0) begin
                    checkVal("l1RspValid", l1RspValid, 1'b1);
                    checkVal("l1RspData", l1Rsp.data, lastWr);
                end
                d = $urandom;
                l1Req.opcode = OP_WR;
                l1Req.data = d;
                lastWr = d;
            end else begin
                checkVal("l1RspIdle", l1RspValid, 1'b0);
                l1Req.opcode = OP_RD;
            end
        end
        @(negedge Clock);
        l1Valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
